// File: rtl/status_flag_unit.sv
// 6502 status register P: merges ALU flags, flag ops, stack pulls and interrupt entry.
// Latency: one cycle for P and undelayed I-mask updates. No backpressure; accepts one update per cycle.
module status_flag_unit #(
  parameter logic [7:0] RESET_P     = 8'h34,
  parameter int         DELAY_I_UPD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] aluStatus,
  input  logic       aluUpdtEn,
  input  logic [7:0] aluMask,
  input  logic [2:0] flagOp,
  input  logic       pullEn,
  input  logic       pullIsRti,
  input  logic [7:0] pullData,
  input  logic       intEntry,
  input  logic       brkFlag,
  input  logic       instrDone,
  input  logic [2:0] branchSel,
  output logic [7:0] status,
  output logic [7:0] pushData,
  output logic       branchTaken,
  output logic       irqMask
);

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_CLC = 3'd1,
    OP_SEC = 3'd2,
    OP_CLI = 3'd3,
    OP_SEI = 3'd4,
    OP_CLV = 3'd5,
    OP_CLD = 3'd6,
    OP_SED = 3'd7
  } flag_op_t;

  localparam int BIT_C = 0;
  localparam int BIT_Z = 1;
  localparam int BIT_I = 2;
  localparam int BIT_D = 3;
  localparam int BIT_V = 6;
  localparam int BIT_N = 7;

  logic [7:0] p;
  logic [7:0] p_next;
  logic       irq_q;
  logic       pend_i;
  logic       i_imm;
  logic       i_dly;
  flag_op_t   op;

  assign op = flag_op_t'(flagOp);

  // Writers applied lowest priority first so later assignments win.
  always_comb begin
    p_next = p;
    if (aluUpdtEn) begin
      p_next = (p & ~aluMask) | (aluStatus & aluMask);
    end
    case (op)
      OP_CLC:  p_next[BIT_C] = 1'b0;
      OP_SEC:  p_next[BIT_C] = 1'b1;
      OP_CLI:  p_next[BIT_I] = 1'b0;
      OP_SEI:  p_next[BIT_I] = 1'b1;
      OP_CLV:  p_next[BIT_V] = 1'b0;
      OP_CLD:  p_next[BIT_D] = 1'b0;
      OP_SED:  p_next[BIT_D] = 1'b1;
      default: p_next = p_next;
    endcase
    if (pullEn) begin
      p_next = pullData;
    end
    if (intEntry) begin
      p_next[BIT_I] = 1'b1;
    end
    p_next[5:4] = 2'b11;
  end

  assign i_imm = intEntry | (pullEn & pullIsRti);
  assign i_dly = (DELAY_I_UPD != 0) && !i_imm &&
                 (pullEn || (op == OP_CLI) || (op == OP_SEI));

  always_ff @(posedge clk) begin
    if (rst) begin
      p      <= RESET_P | 8'h30;
      irq_q  <= RESET_P[BIT_I];
      pend_i <= 1'b0;
    end else begin
      p <= p_next;
      if (i_imm) begin
        irq_q  <= p_next[BIT_I];
        pend_i <= 1'b0;
      end else if (i_dly) begin
        // A new delayed write still lets an older pending copy resolve at this boundary.
        pend_i <= 1'b1;
        if (pend_i && instrDone) begin
          irq_q <= p[BIT_I];
        end
      end else if (pend_i && !instrDone) begin
        pend_i <= 1'b1;
      end else begin
        irq_q  <= p_next[BIT_I];
        pend_i <= 1'b0;
      end
    end
  end

  assign status   = p;
  assign irqMask  = irq_q;
  assign pushData = {p[7:6], 1'b1, brkFlag, p[3:0]};

  always_comb begin
    branchTaken = 1'b0;
    case (branchSel)
      3'd0:    branchTaken = ~p[BIT_N];
      3'd1:    branchTaken =  p[BIT_N];
      3'd2:    branchTaken = ~p[BIT_V];
      3'd3:    branchTaken =  p[BIT_V];
      3'd4:    branchTaken = ~p[BIT_C];
      3'd5:    branchTaken =  p[BIT_C];
      3'd6:    branchTaken = ~p[BIT_Z];
      default: branchTaken =  p[BIT_Z];
    endcase
  end

endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench for status_flag_unit: directed scenarios plus randomized run against a flag-level model.
module tb_status_flag_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] aluStatus;
  logic       aluUpdtEn;
  logic [7:0] aluMask;
  logic [2:0] flagOp;
  logic       pullEn;
  logic       pullIsRti;
  logic [7:0] pullData;
  logic       intEntry;
  logic       brkFlag;
  logic       instrDone;
  logic [2:0] branchSel;
  logic [7:0] status;
  logic [7:0] pushData;
  logic       branchTaken;
  logic       irqMask;

  int total = 0;
  int bad   = 0;

  status_flag_unit #(.RESET_P(8'h34), .DELAY_I_UPD(1)) dut (
    .clk(clk), .rst(rst), .aluStatus(aluStatus), .aluUpdtEn(aluUpdtEn),
    .aluMask(aluMask), .flagOp(flagOp), .pullEn(pullEn), .pullIsRti(pullIsRti),
    .pullData(pullData), .intEntry(intEntry), .brkFlag(brkFlag),
    .instrDone(instrDone), .branchSel(branchSel), .status(status),
    .pushData(pushData), .branchTaken(branchTaken), .irqMask(irqMask)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; aluStatus = 8'h00; aluUpdtEn = 1'b0; aluMask = 8'h00;
    flagOp = 3'd0; pullEn = 1'b0; pullIsRti = 1'b0; pullData = 8'h00;
    intEntry = 1'b0; brkFlag = 1'b0; instrDone = 1'b0; branchSel = 3'd0;
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (status !== 8'h34) begin bad++; $display("FAIL reset_status got=%h exp=34", status); end
    total++; if (irqMask !== 1'b1) begin bad++; $display("FAIL reset_irq got=%b exp=1", irqMask); end
    total++; if (pushData !== 8'h24) begin bad++; $display("FAIL reset_push got=%h exp=24", pushData); end
  endtask

  task automatic test_alu_merge();
    do_reset();
    aluUpdtEn = 1'b1; aluMask = 8'h83; aluStatus = 8'hFF;
    tick();
    idle();
    total++; if (status !== 8'hB7) begin bad++; $display("FAIL alu_merge got=%h exp=B7", status); end
  endtask

  task automatic test_priority();
    do_reset();
    flagOp = 3'd2; aluUpdtEn = 1'b1; aluMask = 8'h01; aluStatus = 8'h00;
    tick();
    idle();
    total++; if (status[0] !== 1'b1) begin bad++; $display("FAIL sec_over_alu got=%b exp=1", status[0]); end
    flagOp = 3'd2; aluUpdtEn = 1'b1; aluMask = 8'hFF; aluStatus = 8'hFF;
    pullEn = 1'b1; pullData = 8'h00;
    tick();
    idle();
    total++; if (status !== 8'h30) begin bad++; $display("FAIL pull_over_all got=%h exp=30", status); end
    total++; if (irqMask !== 1'b1) begin bad++; $display("FAIL plp_irq_delayed got=%b exp=1", irqMask); end
  endtask

  task automatic test_cli_delay();
    do_reset();
    flagOp = 3'd3; instrDone = 1'b1;
    tick();
    idle();
    total++; if (status[2] !== 1'b0) begin bad++; $display("FAIL cli_status_i got=%b exp=0", status[2]); end
    total++; if (irqMask !== 1'b1) begin bad++; $display("FAIL cli_irq_t1 got=%b exp=1", irqMask); end
    tick();
    tick();
    total++; if (irqMask !== 1'b1) begin bad++; $display("FAIL cli_irq_t3 got=%b exp=1", irqMask); end
    instrDone = 1'b1;
    tick();
    idle();
    total++; if (irqMask !== 1'b0) begin bad++; $display("FAIL cli_irq_t4 got=%b exp=0", irqMask); end
  endtask

  task automatic test_rti_int();
    do_reset();
    pullEn = 1'b1; pullIsRti = 1'b1; pullData = 8'hC3;
    tick();
    idle();
    total++; if (status !== 8'hF3) begin bad++; $display("FAIL rti_status got=%h exp=F3", status); end
    total++; if (irqMask !== 1'b0) begin bad++; $display("FAIL rti_irq got=%b exp=0", irqMask); end
    pullEn = 1'b1; pullIsRti = 1'b1; pullData = 8'hC3; intEntry = 1'b1;
    tick();
    idle();
    total++; if (status !== 8'hF7) begin bad++; $display("FAIL rti_int_status got=%h exp=F7", status); end
    total++; if (irqMask !== 1'b1) begin bad++; $display("FAIL rti_int_irq got=%b exp=1", irqMask); end
  endtask

  task automatic test_branch_sweep();
    logic [7:0] pats;
    logic [7:0] exp_vec;
    for (int k = 0; k < 2; k++) begin
      pats = (k == 0) ? 8'h00 : 8'hC3;
      exp_vec = (k == 0) ? 8'b0101_0101 : 8'b1010_1010;  // bit s = expected for branchSel s
      do_reset();
      pullEn = 1'b1; pullData = pats;
      tick();
      idle();
      for (int s = 0; s < 8; s++) begin
        branchSel = 3'(s);
        #1;
        total++;
        if (branchTaken !== exp_vec[s]) begin
          bad++; $display("FAIL branch p=%h sel=%0d got=%b exp=%b", pats, s, branchTaken, exp_vec[s]);
        end
      end
      idle();
    end
  endtask

  // Reference state held as named flags rather than a packed register.
  bit m_n, m_v, m_d, m_i, m_z, m_c;
  bit m_irq;
  bit m_pend;

  function automatic logic [7:0] m_byte(input bit b);
    return {m_n, m_v, 1'b1, b, m_d, m_i, m_z, m_c};
  endfunction

  function automatic bit m_branch(input int sel);
    bit f;
    case (sel / 2)
      0: f = m_n;
      1: f = m_v;
      2: f = m_c;
      default: f = m_z;
    endcase
    return (sel % 2 == 1) ? f : !f;
  endfunction

  task automatic m_step();
    bit old_i;
    bit imm, dly;
    old_i = m_i;
    if (rst) begin
      m_n = 0; m_v = 0; m_d = 0; m_i = 1; m_z = 0; m_c = 0;
      m_irq = 1; m_pend = 0;
      return;
    end
    if (aluUpdtEn) begin
      if (aluMask[7]) m_n = aluStatus[7];
      if (aluMask[6]) m_v = aluStatus[6];
      if (aluMask[3]) m_d = aluStatus[3];
      if (aluMask[2]) m_i = aluStatus[2];
      if (aluMask[1]) m_z = aluStatus[1];
      if (aluMask[0]) m_c = aluStatus[0];
    end
    case (flagOp)
      3'd1: m_c = 0;  3'd2: m_c = 1;  3'd3: m_i = 0;  3'd4: m_i = 1;
      3'd5: m_v = 0;  3'd6: m_d = 0;  3'd7: m_d = 1;  default: ;
    endcase
    if (pullEn) begin
      {m_n, m_v} = pullData[7:6];
      {m_d, m_i, m_z, m_c} = pullData[3:0];
    end
    if (intEntry) m_i = 1;
    imm = intEntry || (pullEn && pullIsRti);
    dly = !imm && (pullEn || flagOp == 3'd3 || flagOp == 3'd4);
    if (m_pend && instrDone) begin m_irq = old_i; m_pend = 0; end
    if (imm) m_pend = 0;
    else if (dly) m_pend = 1;
    if (!m_pend) m_irq = m_i;
  endtask

  task automatic test_random();
    do_reset();
    m_n = 0; m_v = 0; m_d = 0; m_i = 1; m_z = 0; m_c = 0; m_irq = 1; m_pend = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst       = ($urandom_range(0, 49) == 0);
      aluUpdtEn = ($urandom_range(0, 1) == 1);
      aluMask   = 8'($urandom);
      aluStatus = 8'($urandom);
      flagOp    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      pullEn    = ($urandom_range(0, 7) == 0);
      pullIsRti = ($urandom_range(0, 1) == 1);
      pullData  = 8'($urandom);
      intEntry  = ($urandom_range(0, 11) == 0);
      brkFlag   = ($urandom_range(0, 1) == 1);
      instrDone = ($urandom_range(0, 2) == 0);
      branchSel = 3'($urandom);
      #1;
      total++;
      if (pushData !== m_byte(brkFlag)) begin
        bad++; $display("FAIL rand_push cyc=%0d got=%h exp=%h", cyc, pushData, m_byte(brkFlag));
      end
      total++;
      if (branchTaken !== m_branch(int'(branchSel))) begin
        bad++; $display("FAIL rand_branch cyc=%0d got=%b exp=%b", cyc, branchTaken, m_branch(int'(branchSel)));
      end
      m_step();
      @(posedge clk);
      #1;
      total++;
      if (status !== m_byte(1'b1)) begin
        bad++; $display("FAIL rand_status cyc=%0d got=%h exp=%h", cyc, status, m_byte(1'b1));
      end
      total++;
      if (irqMask !== m_irq) begin
        bad++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", cyc, irqMask, m_irq);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_merge();
    test_priority();
    test_cli_delay();
    test_rti_int();
    test_branch_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
